// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one I-mem read at a time and
// hands each returned instruction to decode under a valid/ready handshake.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [31:0] out_raw_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_FLUSH,
    S_WAIT_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pending_pc_q, pending_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_raw_instr_q, out_raw_instr_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [63:0] redirect_aligned;

  assign redirect_aligned = {redirect_pc[63:2], 2'b00};

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pending_pc_d    = pending_pc_q;
    out_valid_d     = out_valid_q;
    out_raw_instr_d = out_raw_instr_q;
    out_pc_d        = out_pc_q;
    case (state_q)
      S_REQ: begin
        if (iresp_data_ok) begin
          if (redirect_valid) begin
            pc_d = redirect_aligned;
          end else begin
            out_valid_d     = 1'b1;
            out_raw_instr_d = iresp_data;
            out_pc_d        = pc_q;
            pc_d            = pc_q + 64'd4;
            state_d         = S_WAIT_OUT;
          end
        end else if (redirect_valid) begin
          // Request address must stay put until the old response returns.
          pending_pc_d = redirect_aligned;
          state_d      = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (iresp_data_ok) begin
          pc_d    = redirect_valid ? redirect_aligned : pending_pc_q;
          state_d = S_REQ;
        end else if (redirect_valid) begin
          pending_pc_d = redirect_aligned;
        end
      end
      S_WAIT_OUT: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          pc_d        = redirect_aligned;
          state_d     = S_REQ;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_REQ;
      pc_q            <= RESET_PC;
      pending_pc_q    <= '0;
      out_valid_q     <= 1'b0;
      out_raw_instr_q <= '0;
      out_pc_q        <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pending_pc_q    <= pending_pc_d;
      out_valid_q     <= out_valid_d;
      out_raw_instr_q <= out_raw_instr_d;
      out_pc_q        <= out_pc_d;
    end
  end

  assign ireq_valid    = (state_q != S_WAIT_OUT) && !reset;
  assign ireq_addr     = pc_q;
  assign out_valid     = out_valid_q;
  assign out_raw_instr = out_raw_instr_q;
  assign out_pc        = out_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: the bench plays instruction memory with variable
// latency and tracks expected fetch behaviour with a transaction-level model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [31:0] out_raw_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  instr_fetch #(.RESET_PC(64'h8000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out_raw_instr (out_raw_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: either a record is waiting for decode, or a fetch is in flight.
  // An in-flight fetch may be doomed, in which case its word is discarded
  // and fetching resumes at the newest redirect target.
  logic [63:0] m_pc;
  bit          m_have_rec;
  logic [31:0] m_rec_instr;
  logic [63:0] m_rec_pc;
  bit          m_doomed;
  logic [63:0] m_target;

  // Memory behaviour
  int unsigned age, cur_lat, lat_lo, lat_hi;
  bit          mem_nop;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (mem_nop) return 32'h0000_0013;
    return a[31:0] ^ {a[63:48], a[15:0]} ^ 32'h5A3C_9E01;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = 64'h8000_0000;
    m_have_rec  = 0;
    m_rec_instr = '0;
    m_rec_pc    = '0;
    m_doomed    = 0;
    m_target    = '0;
    age         = 0;
    cur_lat     = $urandom_range(lat_hi, lat_lo);
  endtask

  task automatic model_update();
    logic [63:0] tgt;
    tgt = redirect_pc & ~64'd3;
    if (m_have_rec) begin
      if (redirect_valid) begin
        m_have_rec = 0;
        m_pc       = tgt;
      end else if (out_ready) begin
        m_have_rec = 0;
      end
    end else if (iresp_data_ok) begin
      if (redirect_valid) m_pc = tgt;
      else if (m_doomed) m_pc = m_target;
      else begin
        m_have_rec  = 1;
        m_rec_instr = iresp_data;
        m_rec_pc    = m_pc;
        m_pc        = m_pc + 64'd4;
      end
      m_doomed = 0;
    end else if (redirect_valid) begin
      m_doomed = 1;
      m_target = tgt;
    end
  endtask

  task automatic check_all();
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, !m_have_rec});
    chk("ireq_addr", ireq_addr, m_pc);
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_have_rec});
    if (m_have_rec) begin
      chk("out_raw_instr", {32'd0, out_raw_instr}, {32'd0, m_rec_instr});
      chk("out_pc", out_pc, m_rec_pc);
    end
  endtask

  task automatic step();
    bit req;
    @(posedge clk);
    req = !m_have_rec;
    model_update();
    if (iresp_data_ok) begin
      age     = 0;
      cur_lat = $urandom_range(lat_hi, lat_lo);
    end else if (req) begin
      age++;
    end
    #1;
    check_all();
  endtask

  task automatic drive(input bit rv, input logic [63:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    iresp_data_ok  = !m_have_rec && (age >= cur_lat);
    iresp_data     = iresp_data_ok ? mem_word(m_pc) : $urandom;
    step();
  endtask

  task automatic check_reset_values();
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_raw", {32'd0, out_raw_instr}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
  endtask

  // Asserts reset asynchronously away from any clock edge, then releases it.
  task automatic do_reset();
    redirect_valid = 0;
    out_ready      = 0;
    iresp_data_ok  = 0;
    @(negedge clk);
    #1 reset = 1;
    #1 check_reset_values();
    @(negedge clk);
    reset = 0;
    model_reset();
    #1 chk("post_rst_ireq_valid", {63'd0, ireq_valid}, 64'd1);
  endtask

  initial begin
    reset          = 1;
    redirect_valid = 0;
    redirect_pc    = '0;
    out_ready      = 0;
    iresp_data_ok  = 0;
    iresp_data     = '0;
    lat_lo = 0; lat_hi = 0; mem_nop = 1;
    model_reset();
    #3 check_reset_values();
    @(negedge clk);
    reset = 0;
    #1 chk("first_req_valid", {63'd0, ireq_valid}, 64'd1);

    // Zero-wait memory, decode always ready
    repeat (8) drive(0, '0, 1);

    // 3-cycle memory, decode stalls after first record
    mem_nop = 0; lat_lo = 3; lat_hi = 3;
    do_reset();
    repeat (10) drive(0, '0, 0);
    repeat (10) drive(0, '0, 1);

    // Redirect during an outstanding request; low bits cleared
    lat_lo = 2; lat_hi = 2;
    do_reset();
    drive(1, 64'h8000_1002, 1);
    repeat (8) drive(0, '0, 1);

    // Two redirects during one outstanding request
    lat_lo = 3; lat_hi = 3;
    do_reset();
    drive(1, 64'h100, 1);
    drive(1, 64'h200, 1);
    repeat (8) drive(0, '0, 1);

    // Redirect with out_ready in WAIT_OUT, then with data_ok in REQ
    lat_lo = 0; lat_hi = 0;
    do_reset();
    drive(0, '0, 1);
    drive(1, 64'h4000, 1);
    drive(1, 64'h5004, 1);
    repeat (6) drive(0, '0, 1);

    // Reset mid-request and mid-WAIT_OUT
    lat_lo = 3; lat_hi = 3;
    do_reset();
    drive(0, '0, 1);
    do_reset();
    lat_lo = 0; lat_hi = 0;
    do_reset();
    drive(0, '0, 0);
    drive(0, '0, 0);
    do_reset();

    // PC wrap at the top of the address space
    drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    drive(0, '0, 0);
    chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_next_pc", ireq_addr, 64'h0);
    repeat (4) drive(0, '0, 1);

    // Randomized traffic
    lat_lo = 0; lat_hi = 3;
    do_reset();
    repeat (600) begin
      drive(($urandom_range(99, 0) < 10), {$urandom, $urandom},
            ($urandom_range(99, 0) < 70));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the pipeline: the producer side of the fetch/decode boundary. It owns the PC, issues one instruction-memory read at a time, and presents each returned 32-bit instruction to decode as a fetch record (raw instruction plus PC) under a valid/ready handshake. It also accepts PC redirects from later stages and squashes stale in-flight fetches.

## Interface
- RESET_PC, 64'h8000_0000, PC of the first fetch after reset
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  out  1  instruction read request
- ireq_addr  out  64  request address, always equals internal pc
- iresp_data_ok  in  1  memory returns data for the current request this cycle
- iresp_data  in  32  instruction word, valid with iresp_data_ok
- out_valid  out  1  fetch record valid to decode
- out_raw_instr  out  32  instruction word (fetch record payload)
- out_pc  out  64  PC of out_raw_instr
- out_ready  in  1  decode accepts record this cycle
- redirect_valid  in  1  later stage requests PC change
- redirect_pc  in  64  new fetch PC; bits [1:0] cleared on capture

## Operation
- Registers: pc, pending_pc, state, output record (out_valid, out_raw_instr, out_pc).
- Memory protocol: once ireq_valid=1, ireq_valid and ireq_addr stay stable until the cycle iresp_data_ok=1; at most one outstanding request; iresp_data_ok may arrive in the request cycle.
- Decode handshake: transfer when out_valid & out_ready; record held stable while out_valid & !out_ready.
- States:
  - REQ: ireq_valid=1. data_ok & !redirect: capture record {iresp_data, pc}, out_valid<=1, pc<=pc+4 → WAIT_OUT. data_ok & redirect: drop data, pc<=redirect_pc → REQ. !data_ok & redirect: pending_pc<=redirect_pc → FLUSH (address must not change mid-request).
  - FLUSH: ireq_valid=1 at old pc. Further redirect overwrites pending_pc (newest wins). data_ok: drop data, pc<=pending_pc (or redirect_pc if redirect this cycle) → REQ.
  - WAIT_OUT: ireq_valid=0, out_valid=1. out_ready & !redirect: out_valid<=0 → REQ. redirect (regardless of out_ready): out_valid<=0, pc<=redirect_pc → REQ; any transfer that same cycle is squashed downstream, fetch takes no further action.
- pc+4 wraps modulo 2^64.
- Dropped responses never reach out_*.

## Timing
- Reset (async, immediate): pc=RESET_PC, pending_pc=0, state=REQ, out_valid=0, out_raw_instr=0, out_pc=0; ireq_valid forced 0 while reset high; ireq_addr=RESET_PC.
- First request: first clk edge after reset release sees ireq_valid=1, ireq_addr=RESET_PC.
- Latency: data_ok in cycle N → out_valid=1 in N+1.
- Peak throughput with zero-wait memory and out_ready=1: one instruction per 2 cycles.
- Redirect in cycle N during REQ with data_ok or WAIT_OUT: request to redirect_pc issued in N+1.
- Redirect during outstanding request: new address issued cycle after data_ok of old request.
- No combinational path from out_ready or redirect_valid to ireq_valid/ireq_addr.

## Test plan
- Reset, zero-wait memory returning 0x00000013 for each address, out_ready=1 → records at pc 0x8000_0000, 0x8000_0004, 0x8000_0008 on every other cycle; ireq_addr steps by 4.
- Memory 3-cycle latency, out_ready held 0 for 5 cycles after first record → ireq_valid/ireq_addr stable through wait, out_valid/out_pc/out_raw_instr stable until ready, no second request issued.
- Redirect to 0x8000_1002 while request to 0x8000_0000 outstanding (data_ok 2 cycles later) → ireq_addr stays 0x8000_0000 until data_ok, that data never appears, next ireq_addr=0x8000_1000.
- Two redirects (0x100, then 0x200) during one outstanding request → next fetch at 0x200 only.
- Redirect in same cycle as out_ready in WAIT_OUT, and in same cycle as data_ok in REQ → out_valid 0 next cycle, next ireq_addr=redirect_pc, dropped word never presented.
- Assert reset mid-request and mid-WAIT_OUT → outputs return to reset values immediately; redirect to 0xFFFF_FFFF_FFFF_FFFC then fetch → next pc wraps to 0x0.
